bsr_receiver: RTL and testbench
===============================

# bsr_receiver

Bit-stream receiver: the receive-side counterpart of the BSG transmit path. It samples the 8-bit modulated line, detects frames, slices four 4-level amplitude symbols per byte, Gray-decodes the assembled byte, and stores it into two ping-pong data registers. Software accesses the control and data registers through the same valid/ready register port used by the BSG transmitter. It raises an interrupt when a byte has been received.

## Interface

Parameters:
- SPS, 8: samples per symbol; must be even and ≥4.
- IDLE_TH, 8'h10: a sample below this value is treated as idle line.

Ports:
- SYS_CLK  in  1  single clock for all logic.
- SYS_RST_N  in  1  reset, asynchronous and active-low.
- SAMPLE_EN  in  1  one-cycle strobe marking a valid line sample on IN.
- IN  in  8  modulated line sample.
- BSR_INT  out  1  interrupt, equal to INTFLAG & INTMSK.
- Data_in  in  8  register write data.
- addr  in  8  register address: 0x00 BSR_CONTROL, 0x01 BSR_DATA_0, 0x02 BSR_DATA_1.
- wr  in  1  1 = write, 0 = read; qualified by valid.
- valid  in  1  transaction request.
- Data_out  out  8  read data; valid while ready is high.
- ready  out  1  one-cycle transaction acknowledge.

## Operation

BSR_CONTROL bits:
- 0: RXEN (RW).
- 1: INTMSK (RW; 1 = interrupt enabled).
- 2: INTFLAG (write 1 to clear).
- 3: BUSY (RO).
- 4: OVERRUN (W1C).
- 5: FULL0 (RO).
- 6: FULL1 (RO).
- 7: FRMERR (W1C).

Modulation: each byte is sent as 4 dibits, MSB dibit first, each held for SPS samples.
- Levels 0x20, 0x60, 0xA0, 0xE0 encode dibits 00, 01, 10, 11.
- The idle line value is 0x00.

Slicer: a sample below 0x40 gives 0, below 0x80 gives 1, below 0xC0 gives 2, otherwise 3.

FSM, advanced only on SAMPLE_EN:
- IDLE: if RXEN is set and IN ≥ IDLE_TH, go to RECV with cnt=0; this strobe is sample 0 of symbol 0.
- RECV:
  - cnt increments on every strobe from 0 to 4·SPS−1.
  - When cnt mod SPS == SPS/2, slice IN and shift the dibit in.
  - If IN < IDLE_TH at a slice point, abort to IDLE, set FRMERR, and discard the byte.
  - At the 4th slice (cnt = 3·SPS+SPS/2), store the byte.
  - At cnt = 4·SPS−1, return to IDLE.
- BUSY = (state == RECV).
- Clearing RXEN forces IDLE on the next clock and discards any partial byte.

Store:
- Gray-decode the byte: b[7]=g[7], b[i]=b[i+1]^g[i].
- Write it to the slot selected by the write pointer wp (0 after reset), set that slot's FULL bit, toggle wp, and set INTFLAG.
- If the target slot is already FULL, overwrite it and set OVERRUN.

Register access:
- Reading BSR_DATA_n returns the stored byte and clears FULLn.
- Unmapped addresses read 0x00; writes to them are ignored; they are still acknowledged.
- Writes to BSR_DATA_n are ignored.

## Timing

- Reset values:
  - All registers, including wp and the FSM (IDLE), are 0.
  - Data_out=0x00, ready=0, BSR_INT=0.
- Transaction handshake:
  - A transaction is accepted on a cycle with valid=1 and ready=0.
  - ready is 1 on the next cycle for exactly one cycle; Data_out is registered and valid in that cycle.
  - valid seen during the ready cycle is ignored.
  - The requester drops valid on seeing ready.
- Store latency: the data register, FULL, INTFLAG and BSR_INT update on the SYS_CLK edge after the 4th slice strobe.
- Simultaneous events:
  - A store and a read-clear of the same slot in the same cycle: the store wins, FULL stays 1, and the read returns the old byte.
  - A store and a W1C of INTFLAG in the same cycle: the set wins.
  - A store and a control write: hardware sets of INTFLAG/OVERRUN take priority over the W1C.
- Back-to-back frames: the strobe after cnt = 4·SPS−1 is evaluated in IDLE, so contiguous bytes with no idle gap are received.
- Reset asserted mid-frame: immediate return to reset values; the partial byte is lost.

## Configuration

- BSR_GRAY_DECODE_EN:
  - Defined: the stored byte is Gray-decoded.
  - Undefined: the assembled byte is stored raw, and the decoder logic is absent.
- All other behaviour is identical in both builds.

## Test plan

- SPS=8, RXEN=1, INTMSK=1; line 0x60,0xE0,0x60,0xE0 (8 strobes each) → BSR_DATA_0=0x5A, FULL0=1, INTFLAG=1, BSR_INT=1; without the macro → 0x77.
- Two contiguous frames for 0x5A then 0x00 (levels 0x20×4) → DATA_0=0x5A, DATA_1=0x00, FULL0=FULL1=1, wp=0.
- Third frame 0xFF with both slots full → DATA_0=0xFF, OVERRUN=1; read of addr 0x01 → Data_out=0xFF with ready one cycle after valid, FULL0 cleared.
- Line drops to 0x00 at the 3rd slice → FRMERR=1, no store, FSM returns to IDLE; write 0x80 to 0x00 → FRMERR=0.
- Clear RXEN mid-frame, then assert SYS_RST_N=0 mid-frame on a second attempt → BUSY=0 on the next clock with no store; after reset all registers read 0x00.
- Store and read of the same slot in one cycle → read returns the old byte, FULL stays 1; store and W1C of INTFLAG in one cycle → INTFLAG=1.

Source files
------------

// File: rtl/bsr_receiver.sv
`default_nettype none
// =============================================================================
// bsr_receiver : 4-level bit-stream receiver with ping-pong data registers.
// Optional macro BSR_GRAY_DECODE_EN stores the Gray-decoded byte.
// Revision: 1.0
// =============================================================================
module bsr_receiver #(
    parameter int         SPS     = 8,
    parameter logic [7:0] IDLE_TH = 8'h10
) (
    input  logic       SYS_CLK,
    input  logic       SYS_RST_N,
    input  logic       SAMPLE_EN,
    input  logic [7:0] IN,
    output logic       BSR_INT,
    input  logic [7:0] Data_in,
    input  logic [7:0] addr,
    input  logic       wr,
    input  logic       valid,
    output logic [7:0] Data_out,
    output logic       ready
);

    localparam int              c_PW     = (SPS > 2) ? $clog2(SPS) : 1;
    localparam logic [c_PW-1:0] c_P_ONE  = c_PW'(1);
    localparam logic [c_PW-1:0] c_P_LAST = c_PW'(SPS - 1);
    localparam logic [c_PW-1:0] c_P_MID  = c_PW'(SPS / 2);
    localparam logic [0:0]      c_S_IDLE = 1'b0;
    localparam logic [0:0]      c_S_RECV = 1'b1;
    localparam logic [7:0]      c_A_CTRL = 8'h00;
    localparam logic [7:0]      c_A_D0   = 8'h01;
    localparam logic [7:0]      c_A_D1   = 8'h02;

    logic [0:0]      r_state;
    logic [c_PW-1:0] r_pos;
    logic [1:0]      r_sym;
    logic [5:0]      r_shift;
    logic            r_rxen, r_intmsk, r_intflag, r_ovr, r_frmerr, r_wp;
    logic [1:0]      r_full;
    logic [7:0]      r_data0, r_data1, r_dout;
    logic            r_ready;

    logic [c_PW-1:0] w_pos_nxt;
    logic [1:0]      w_sym_nxt;
    logic            w_recv_stb, w_line_idle, w_slice, w_abort, w_store, w_end;
    logic [7:0]      w_raw, w_store_byte, w_rdata, w_ctrl;
    logic            w_accept, w_wr_ctrl, w_rd_d0, w_rd_d1;
    logic            w_unused_din;

    // Sample position within the frame, split into symbol index and in-symbol offset.
    assign w_pos_nxt   = (r_pos == c_P_LAST) ? '0 : r_pos + c_P_ONE;
    assign w_sym_nxt   = (r_pos == c_P_LAST) ? r_sym + 2'd1 : r_sym;
    assign w_recv_stb  = SAMPLE_EN && r_rxen && (r_state == c_S_RECV);
    assign w_line_idle = (IN < IDLE_TH);
    assign w_slice     = w_recv_stb && (w_pos_nxt == c_P_MID);
    assign w_abort     = w_slice && w_line_idle;
    assign w_store     = w_slice && !w_line_idle && (w_sym_nxt == 2'd3);
    assign w_end       = w_recv_stb && (w_sym_nxt == 2'd3) && (w_pos_nxt == c_P_LAST);
    // The slicer thresholds fall on multiples of 0x40, so the dibit is IN[7:6].
    assign w_raw       = {r_shift, IN[7:6]};

`ifdef BSR_GRAY_DECODE_EN
    for (genvar i = 0; i < 8; i++) begin : g_gray
        assign w_store_byte[i] = ^w_raw[7:i];
    end
`else
    assign w_store_byte = w_raw;
`endif

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            r_state <= c_S_IDLE;
            r_pos   <= '0;
            r_sym   <= 2'd0;
            r_shift <= 6'd0;
        end else if (!r_rxen) begin
            r_state <= c_S_IDLE;
        end else if (SAMPLE_EN) begin
            case (r_state)
                c_S_IDLE: begin
                    if (!w_line_idle) begin
                        r_state <= c_S_RECV;
                        r_pos   <= '0;
                        r_sym   <= 2'd0;
                    end
                end
                c_S_RECV: begin
                    r_pos <= w_pos_nxt;
                    r_sym <= w_sym_nxt;
                    if (w_slice) r_shift <= w_raw[5:0];
                    if (w_abort || w_end) r_state <= c_S_IDLE;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign w_accept     = valid && !r_ready;
    assign w_wr_ctrl    = w_accept && wr && (addr == c_A_CTRL);
    assign w_rd_d0      = w_accept && !wr && (addr == c_A_D0);
    assign w_rd_d1      = w_accept && !wr && (addr == c_A_D1);
    assign w_unused_din = ^{Data_in[6:5], Data_in[3]};
    assign w_ctrl       = {r_frmerr, r_full[1], r_full[0], r_ovr,
                           (r_state == c_S_RECV), r_intflag, r_intmsk, r_rxen};

    always_comb begin
        w_rdata = 8'h00;
        case (addr)
            c_A_CTRL: w_rdata = w_ctrl;
            c_A_D0:   w_rdata = r_data0;
            c_A_D1:   w_rdata = r_data1;
            default:  w_rdata = 8'h00;
        endcase
    end

    // Software clears are applied first so that same-cycle hardware sets win.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            r_rxen    <= 1'b0;
            r_intmsk  <= 1'b0;
            r_intflag <= 1'b0;
            r_ovr     <= 1'b0;
            r_frmerr  <= 1'b0;
            r_full    <= 2'b00;
            r_wp      <= 1'b0;
            r_data0   <= 8'h00;
            r_data1   <= 8'h00;
        end else begin
            if (w_wr_ctrl) begin
                r_rxen   <= Data_in[0];
                r_intmsk <= Data_in[1];
                if (Data_in[2]) r_intflag <= 1'b0;
                if (Data_in[4]) r_ovr     <= 1'b0;
                if (Data_in[7]) r_frmerr  <= 1'b0;
            end
            if (w_rd_d0) r_full[0] <= 1'b0;
            if (w_rd_d1) r_full[1] <= 1'b0;
            if (w_abort) r_frmerr <= 1'b1;
            if (w_store) begin
                if (r_full[r_wp]) r_ovr <= 1'b1;
                if (r_wp) r_data1 <= w_store_byte;
                else      r_data0 <= w_store_byte;
                r_full[r_wp] <= 1'b1;
                r_wp         <= ~r_wp;
                r_intflag    <= 1'b1;
            end
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            r_ready <= 1'b0;
            r_dout  <= 8'h00;
        end else begin
            r_ready <= w_accept;
            if (w_accept) r_dout <= wr ? 8'h00 : w_rdata;
        end
    end

    assign ready    = r_ready;
    assign Data_out = r_dout;
    assign BSR_INT  = r_intflag & r_intmsk;

endmodule
`default_nettype wire

// File: tb/tb_bsr_receiver.sv
`default_nettype none
// =============================================================================
// tb_bsr_receiver : directed/random frames checked against a register-level model.
// Revision: 1.0
// =============================================================================
module tb_bsr_receiver;

    localparam int SPS = 8;

    logic       clk = 1'b0;
    logic       rst_n, sample_en, wr, valid;
    logic [7:0] in_s, din, addr;
    logic       bsr_int, ready;
    logic [7:0] dout;
    logic [7:0] rd_tmp;

    always #5 clk = ~clk;

    bsr_receiver #(.SPS(SPS), .IDLE_TH(8'h10)) u_dut (
        .SYS_CLK  (clk),
        .SYS_RST_N(rst_n),
        .SAMPLE_EN(sample_en),
        .IN       (in_s),
        .BSR_INT  (bsr_int),
        .Data_in  (din),
        .addr     (addr),
        .wr       (wr),
        .valid    (valid),
        .Data_out (dout),
        .ready    (ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_data [2];
    logic [1:0] m_full;
    logic       m_wp, m_intflag, m_ovr, m_frmerr, m_rxen, m_intmsk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] decode(input logic [7:0] g);
`ifdef BSR_GRAY_DECODE_EN
        logic [7:0] b = 8'h00;
        for (int s = 0; s < 8; s++) b = b ^ (g >> s);
        return b;
`else
        return g;
`endif
    endfunction

    function automatic logic [7:0] m_ctrl(input logic busy);
        return {m_frmerr, m_full[1], m_full[0], m_ovr, busy, m_intflag, m_intmsk, m_rxen};
    endfunction

    task automatic m_reset();
        m_data[0] = 8'h00; m_data[1] = 8'h00; m_full = 2'b00; m_wp = 1'b0;
        m_intflag = 1'b0; m_ovr = 1'b0; m_frmerr = 1'b0; m_rxen = 1'b0; m_intmsk = 1'b0;
    endtask

    task automatic m_store(input logic [7:0] g);
        if (m_full[m_wp]) m_ovr = 1'b1;
        m_data[m_wp] = decode(g);
        m_full[m_wp] = 1'b1;
        m_wp         = ~m_wp;
        m_intflag    = 1'b1;
    endtask

    // Line level of sample k of a frame carrying g; drop>=0 silences the line from that symbol's slice point.
    function automatic logic [7:0] frame_lvl(input logic [7:0] g, input int k, input int drop);
        int         sym = k / SPS;
        logic [7:0] gg  = g;
        logic [1:0] d;
        if (drop >= 0 && k >= drop * SPS + SPS / 2) return 8'h00;
        d = gg[7 - 2 * sym -: 2];
        return 8'h20 + 8'(int'(d) * 64);
    endfunction

    task automatic strobe(input logic [7:0] lvl);
        sample_en = 1'b1;
        in_s      = lvl;
        @(negedge clk);
        sample_en = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] g, input int drop, input int first, input int last);
        for (int k = first; k <= last; k++) strobe(frame_lvl(g, k, drop));
    endtask

    task automatic bus(input logic w, input logic [7:0] a, input logic [7:0] d, output logic [7:0] rd);
        int n = 0;
        valid = 1'b1; wr = w; addr = a; din = d;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n++;
            if (ready) break;
        end
        check("ready_latency", 8'(n), 8'd1);
        rd    = dout;
        valid = 1'b0;
        wr    = 1'b0;
        @(negedge clk);
        check("ready_one_cycle", {7'd0, ready}, 8'd0);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] rd;
        bus(1'b0, a, 8'h00, rd);
        check(tag, rd, exp);
    endtask

    task automatic rd_data(input logic slot);
        rd_check(slot ? "data1" : "data0", 8'({7'd0, slot}) + 8'd1, m_data[slot]);
        m_full[slot] = 1'b0;
    endtask

    task automatic wr_ctrl(input logic [7:0] d);
        logic [7:0] rd;
        bus(1'b1, 8'h00, d, rd);
        m_rxen   = d[0];
        m_intmsk = d[1];
        if (d[2]) m_intflag = 1'b0;
        if (d[4]) m_ovr     = 1'b0;
        if (d[7]) m_frmerr  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] g, g2, g3;
        logic       y;

        rst_n = 1'b0; sample_en = 1'b0; in_s = 8'h00; din = 8'h00;
        addr = 8'h00; wr = 1'b0; valid = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", {7'd0, ready}, 8'd0);
        check("rst_dout", dout, 8'h00);
        check("rst_int", {7'd0, bsr_int}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        rd_check("rst_ctrl", 8'h00, 8'h00);
        rd_check("rst_d0", 8'h01, 8'h00);
        rd_check("rst_d1", 8'h02, 8'h00);
        rd_check("unmapped", 8'h33, 8'h00);
        bus(1'b1, 8'h01, 8'hAB, rd_tmp);
        rd_check("d0_write_ignored", 8'h01, 8'h00);

        wr_ctrl(8'h03);
        rd_check("ctrl_enabled", 8'h00, m_ctrl(1'b0));

        // Plan frame: levels 0x60,0xE0,0x60,0xE0
        g = 8'h77;
        send_frame(g, -1, 0, 31); m_store(g);
        strobe(8'h00); strobe(8'h00);
        rd_check("ctrl_after_first", 8'h00, m_ctrl(1'b0));
        check("int_after_first", {7'd0, bsr_int}, {7'd0, m_intflag & m_intmsk});
        rd_data(1'b0);
        wr_ctrl(8'h07);
        check("int_cleared", {7'd0, bsr_int}, 8'd0);

        // Contiguous frames, then an overrun frame
        g = 8'($urandom); g2 = 8'($urandom); g3 = 8'($urandom);
        send_frame(g, -1, 0, 31); m_store(g);
        send_frame(g2, -1, 0, 31); m_store(g2);
        strobe(8'h00);
        rd_check("ctrl_both_full", 8'h00, m_ctrl(1'b0));
        send_frame(g3, -1, 0, 31); m_store(g3);
        strobe(8'h00);
        rd_check("ctrl_overrun", 8'h00, m_ctrl(1'b0));
        rd_data(1'b0);
        rd_data(1'b1);
        rd_check("ctrl_emptied", 8'h00, m_ctrl(1'b0));
        wr_ctrl(8'h17);

        // Line drops at the third slice
        g = 8'($urandom) | 8'h01;
        send_frame(g, 2, 0, 31); m_frmerr = 1'b1;
        strobe(8'h00);
        rd_check("ctrl_frmerr", 8'h00, m_ctrl(1'b0));
        wr_ctrl(8'h83);
        rd_check("ctrl_frmerr_clr", 8'h00, m_ctrl(1'b0));

        // Store and read-clear of the same slot in one cycle
        y = m_wp;
        g = 8'($urandom);
        if (decode(g) == m_data[y]) g = g ^ 8'h01;
        send_frame(g, -1, 0, 3 * SPS + SPS / 2 - 1);
        sample_en = 1'b1; in_s = frame_lvl(g, 3 * SPS + SPS / 2, -1);
        valid = 1'b1; wr = 1'b0; addr = 8'({7'd0, y}) + 8'd1;
        @(negedge clk);
        sample_en = 1'b0;
        check("simul_rd_ready", {7'd0, ready}, 8'd1);
        check("simul_rd_old", dout, m_data[y]);
        valid = 1'b0;
        @(negedge clk);
        m_full[y] = 1'b0;
        m_store(g);
        send_frame(g, -1, 3 * SPS + SPS / 2 + 1, 31);
        rd_check("ctrl_store_wins", 8'h00, m_ctrl(1'b0));
        rd_data(y);

        // Store and W1C of INTFLAG in one cycle
        g = 8'($urandom);
        send_frame(g, -1, 0, 3 * SPS + SPS / 2 - 1);
        sample_en = 1'b1; in_s = frame_lvl(g, 3 * SPS + SPS / 2, -1);
        valid = 1'b1; wr = 1'b1; addr = 8'h00; din = 8'h07;
        @(negedge clk);
        sample_en = 1'b0;
        check("simul_w1c_ready", {7'd0, ready}, 8'd1);
        valid = 1'b0; wr = 1'b0;
        @(negedge clk);
        m_intflag = 1'b0;
        m_store(g);
        send_frame(g, -1, 3 * SPS + SPS / 2 + 1, 31);
        rd_check("ctrl_set_wins", 8'h00, m_ctrl(1'b0));
        check("int_set_wins", {7'd0, bsr_int}, 8'd1);

        // RXEN cleared mid-frame
        g = 8'($urandom);
        send_frame(g, -1, 0, 11);
        rd_check("ctrl_busy", 8'h00, m_ctrl(1'b1));
        wr_ctrl(8'h02);
        rd_check("ctrl_rxen_off", 8'h00, m_ctrl(1'b0));
        send_frame(g, -1, 12, 31);
        strobe(8'h00);
        rd_check("ctrl_no_store", 8'h00, m_ctrl(1'b0));
        wr_ctrl(8'h03);

        // Reset mid-frame
        g = 8'($urandom);
        send_frame(g, -1, 0, 9);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {7'd0, ready}, 8'd0);
        check("mid_rst_dout", dout, 8'h00);
        check("mid_rst_int", {7'd0, bsr_int}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
        rd_check("post_rst_ctrl", 8'h00, 8'h00);
        rd_check("post_rst_d0", 8'h01, 8'h00);
        rd_check("post_rst_d1", 8'h02, 8'h00);

        // Write pointer restarts at slot 0
        wr_ctrl(8'h03);
        g = 8'($urandom);
        send_frame(g, -1, 0, 31); m_store(g);
        strobe(8'h00);
        rd_check("ctrl_wp_reset", 8'h00, m_ctrl(1'b0));
        rd_data(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
